// File: rtl/id_operand_stage_pkg.sv
// Shared decode constants and helpers for the ID operand stage.
package id_operand_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int RD_LSB = 0;
  localparam int RJ_LSB = 5;
  localparam int RK_LSB = 10;
  localparam int OP_LSB = 20;

  localparam logic [9:0]  OP_STW       = 10'b0010100110;
  localparam logic [5:0]  OP_BEQ       = 6'b010110;
  localparam logic [5:0]  OP_BNE       = 6'b010111;
  localparam logic [6:0]  OP_LU12I     = 7'b0001010;
  localparam logic [5:0]  OP_B         = 6'b010100;
  localparam logic [5:0]  OP_BL        = 6'b010101;
  localparam logic [11:0] OP_3R_PREFIX = 12'h001;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic [XLEN-1:0]   data;
  } fwd_t;

  typedef struct packed {
    logic src2_is_rd;
    logic uses_rj;
    logic uses_src2;
  } dec_t;

  // op is inst[31:20]; every opcode class is identifiable from those bits.
  function automatic dec_t decode(input logic [11:0] op);
    dec_t d;
    d.src2_is_rd = (op[11:2] == OP_STW) | (op[11:6] == OP_BEQ) | (op[11:6] == OP_BNE);
    d.uses_rj    = !((op[11:5] == OP_LU12I) | (op[11:6] == OP_B) | (op[11:6] == OP_BL));
    d.uses_src2  = (op == OP_3R_PREFIX) | d.src2_is_rd;
    return d;
  endfunction

endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// Operand bypass select: EX > MEM > WB > regfile, with r0 forced to zero.
module fwd_mux
  import id_operand_stage_pkg::*;
(
  input  logic [REG_AW-1:0] addr_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  fwd_t              es_i,
  input  fwd_t              ms_i,
  input  fwd_t              ws_i,
  output logic [XLEN-1:0]   operand_o
);

  logic es_hit, ms_hit, ws_hit;

  assign es_hit = es_i.valid & (es_i.dest == addr_i);
  assign ms_hit = ms_i.valid & (ms_i.dest == addr_i);
  assign ws_hit = ws_i.valid & (ws_i.dest == addr_i);

  always_comb begin
    operand_o = rf_data_i;
    if (addr_i == '0) begin
      operand_o = '0;
    end else if (es_hit) begin
      operand_o = es_i.data;
    end else if (ms_hit) begin
      operand_o = ms_i.data;
    end else if (ws_hit) begin
      operand_o = ws_i.data;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage slot: holds IF's instruction, drives regfile reads, bypasses
// later-stage results and stalls on load-use hazards.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fs_to_ds_valid,
  input  logic [31:0]       fs_pc,
  input  logic [31:0]       fs_inst,
  output logic              ds_allowin,
  input  logic              br_cancel,
  output logic [4:0]        raddr1,
  output logic [4:0]        raddr2,
  input  logic [31:0]       rdata1,
  input  logic [31:0]       rdata2,
  input  logic              es_fwd_valid,
  input  logic [4:0]        es_fwd_dest,
  input  logic [31:0]       es_fwd_data,
  input  logic              ms_fwd_valid,
  input  logic [4:0]        ms_fwd_dest,
  input  logic [31:0]       ms_fwd_data,
  input  logic              ws_fwd_valid,
  input  logic [4:0]        ws_fwd_dest,
  input  logic [31:0]       ws_fwd_data,
  input  logic              es_is_load,
  input  logic              es_allowin,
  output logic              ds_to_es_valid,
  output logic [31:0]       ds_pc,
  output logic [31:0]       ds_inst,
  output logic [31:0]       src1_val,
  output logic [31:0]       src2_val,
  output logic [PERF_W-1:0] stall_cnt
);

  logic              ds_valid_q, ds_valid_d;
  logic [31:0]       ds_pc_q, ds_inst_q;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  dec_t              dec;
  fwd_t              es_fwd, ms_fwd, ws_fwd;
  logic [REG_AW-1:0] src_addr [2];
  logic [XLEN-1:0]   rf_data  [2];
  logic [XLEN-1:0]   src_val  [2];
  logic [1:0]        src_used;
  logic [1:0]        load_hit;
  logic              hazard, ds_ready_go, load_en;

  assign dec = decode(ds_inst_q[31:OP_LSB]);

  assign src_addr[0] = ds_inst_q[RJ_LSB +: REG_AW];
  assign src_addr[1] = dec.src2_is_rd ? ds_inst_q[RD_LSB +: REG_AW]
                                      : ds_inst_q[RK_LSB +: REG_AW];
  assign src_used    = {dec.uses_src2, dec.uses_rj};
  assign rf_data[0]  = rdata1;
  assign rf_data[1]  = rdata2;

  assign es_fwd = '{valid: es_fwd_valid, dest: es_fwd_dest, data: es_fwd_data};
  assign ms_fwd = '{valid: ms_fwd_valid, dest: ms_fwd_dest, data: ms_fwd_data};
  assign ws_fwd = '{valid: ws_fwd_valid, dest: ws_fwd_dest, data: ws_fwd_data};

  // Operands stay combinational so a stalled instruction picks up forwarded
  // data the moment the producing stage delivers it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      fwd_mux u_fwd_mux (
        .addr_i    (src_addr[gi]),
        .rf_data_i (rf_data[gi]),
        .es_i      (es_fwd),
        .ms_i      (ms_fwd),
        .ws_i      (ws_fwd),
        .operand_o (src_val[gi])
      );
      assign load_hit[gi] = src_used[gi] & (es_fwd_dest == src_addr[gi]);
    end
  endgenerate

  assign hazard      = ds_valid_q & es_fwd_valid & es_is_load
                     & (es_fwd_dest != '0) & (|load_hit);
  assign ds_ready_go = ~hazard;

  assign ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin);
  assign ds_to_es_valid = ds_valid_q & ds_ready_go & ~br_cancel;
  assign load_en        = fs_to_ds_valid & ds_allowin & ~br_cancel;

  always_comb begin
    ds_valid_d  = ds_valid_q;
    stall_cnt_d = stall_cnt_q;
    if (br_cancel) begin
      ds_valid_d = 1'b0;
    end else if (ds_allowin) begin
      ds_valid_d = fs_to_ds_valid;
    end
    if (hazard && !br_cancel) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_valid_q  <= 1'b0;
      ds_pc_q     <= '0;
      ds_inst_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ds_valid_q  <= ds_valid_d;
      stall_cnt_q <= stall_cnt_d;
      if (load_en) begin
        ds_pc_q   <= fs_pc;
        ds_inst_q <= fs_inst;
      end
    end
  end

  assign raddr1    = src_addr[0];
  assign raddr2    = src_addr[1];
  assign src1_val  = src_val[0];
  assign src2_val  = src_val[1];
  assign ds_pc     = ds_pc_q;
  assign ds_inst   = ds_inst_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: directed cases, then random traffic
// checked against a behavioural model of the decode slot.
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fs_to_ds_valid = 1'b0;
  logic [31:0] fs_pc = '0, fs_inst = '0;
  logic        ds_allowin;
  logic        br_cancel = 1'b0;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        es_fwd_valid = 1'b0, ms_fwd_valid = 1'b0, ws_fwd_valid = 1'b0;
  logic [4:0]  es_fwd_dest = '0, ms_fwd_dest = '0, ws_fwd_dest = '0;
  logic [31:0] es_fwd_data = '0, ms_fwd_data = '0, ws_fwd_data = '0;
  logic        es_is_load = 1'b0;
  logic        es_allowin = 1'b1;
  logic        ds_to_es_valid;
  logic [31:0] ds_pc, ds_inst, src1_val, src2_val;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] regs [32];
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  typedef enum int {K_3R, K_STW, K_BEQ, K_BNE, K_LU12I, K_B, K_BL, K_OTHER} kind_e;

  item_t       exp_q [$];
  logic [31:0] m_cnt = '0;
  bit          acc_flag = 1'b0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  id_operand_stage #(.PERF_W(32)) dut (
    .clk(clk), .reset(reset),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst),
    .ds_allowin(ds_allowin), .br_cancel(br_cancel),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .es_fwd_valid(es_fwd_valid), .es_fwd_dest(es_fwd_dest), .es_fwd_data(es_fwd_data),
    .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest), .ms_fwd_data(ms_fwd_data),
    .ws_fwd_valid(ws_fwd_valid), .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data),
    .es_is_load(es_is_load), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_pc(ds_pc), .ds_inst(ds_inst),
    .src1_val(src1_val), .src2_val(src2_val), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic kind_e kind_of(input logic [31:0] i);
    if (i[31:20] == 12'h001)         return K_3R;
    if (i[31:22] == 10'b0010100110)  return K_STW;
    if (i[31:26] == 6'b010110)       return K_BEQ;
    if (i[31:26] == 6'b010111)       return K_BNE;
    if (i[31:25] == 7'b0001010)      return K_LU12I;
    if (i[31:26] == 6'b010100)       return K_B;
    if (i[31:26] == 6'b010101)       return K_BL;
    return K_OTHER;
  endfunction

  function automatic logic [31:0] mk(input kind_e k, input logic [4:0] rd,
                                     input logic [4:0] rj, input logic [4:0] rk);
    logic [31:0] r;
    r = $urandom;
    case (k)
      K_3R:    return {12'h001, r[4:0], rk, rj, rd};
      K_STW:   return {10'b0010100110, r[11:0], rj, rd};
      K_BEQ:   return {6'b010110, r[15:0], rj, rd};
      K_BNE:   return {6'b010111, r[15:0], rj, rd};
      K_LU12I: return {7'b0001010, r[14:0], rj, rd};
      K_B:     return {6'b010100, r[15:0], rj, rd};
      K_BL:    return {6'b010101, r[15:0], rj, rd};
      default: return {10'b0000001010, r[11:0], rj, rd};
    endcase
  endfunction

  // Value a source register should resolve to given the bypass inputs right now.
  function automatic logic [31:0] resolve(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (es_fwd_valid && es_fwd_dest == a) return es_fwd_data;
    if (ms_fwd_valid && ms_fwd_dest == a) return ms_fwd_data;
    if (ws_fwd_valid && ws_fwd_dest == a) return ws_fwd_data;
    return regs[a];
  endfunction

  // Monitor: compares the DUT against the instruction at the head of the queue.
  always @(negedge clk) begin : monitor
    item_t       cur;
    bit          have, haz, e_out, e_allow, u1, u2;
    kind_e       k;
    logic [4:0]  a1, a2;
    if (reset) begin
      acc_flag = 1'b0;
    end else begin
      have = (exp_q.size() != 0);
      cur  = have ? exp_q[0] : '0;
      k    = kind_of(cur.inst);
      a1   = cur.inst[9:5];
      a2   = (k == K_STW || k == K_BEQ || k == K_BNE) ? cur.inst[4:0] : cur.inst[14:10];
      u1   = !(k == K_LU12I || k == K_B || k == K_BL);
      u2   = (k == K_3R || k == K_STW || k == K_BEQ || k == K_BNE);
      haz  = have && es_fwd_valid && es_is_load && es_fwd_dest != 5'd0 &&
             ((u1 && es_fwd_dest == a1) || (u2 && es_fwd_dest == a2));
      e_out   = have && !haz && !br_cancel;
      e_allow = !have || (!haz && es_allowin);
      chk("ds_to_es_valid", 32'(ds_to_es_valid), 32'(e_out));
      chk("ds_allowin", 32'(ds_allowin), 32'(e_allow));
      chk("stall_cnt", stall_cnt, m_cnt);
      if (have) begin
        chk("raddr1", 32'(raddr1), 32'(a1));
        chk("raddr2", 32'(raddr2), 32'(a2));
      end
      if (e_out && es_allowin) begin
        void'(exp_q.pop_front());
        chk("ds_pc", ds_pc, cur.pc);
        chk("ds_inst", ds_inst, cur.inst);
        chk("src1_val", src1_val, resolve(a1));
        chk("src2_val", src2_val, resolve(a2));
        $display("issue pc=%h inst=%h src1=%h src2=%h stalls=%0d",
                 ds_pc, ds_inst, src1_val, src2_val, stall_cnt);
      end else if (br_cancel && have) begin
        void'(exp_q.pop_front());
      end
      if (haz && !br_cancel) m_cnt = m_cnt + 32'd1;
      acc_flag = e_allow;
    end
  end

  task automatic tick(output bit accepted);
    @(posedge clk);
    accepted = !reset && fs_to_ds_valid && acc_flag && !br_cancel;
    if (accepted) exp_q.push_back(item_t'{pc: fs_pc, inst: fs_inst});
    #1;
  endtask

  task automatic offer(input logic [31:0] inst);
    bit acc;
    fs_to_ds_valid = 1'b1;
    fs_inst = inst;
    fs_pc   = pc_ctr;
    pc_ctr  = pc_ctr + 32'd4;
    tick(acc);
    chk("accept", 32'(acc), 32'd1);
    fs_to_ds_valid = 1'b0;
  endtask

  task automatic clear_fwd();
    es_fwd_valid = 1'b0; ms_fwd_valid = 1'b0; ws_fwd_valid = 1'b0;
    es_is_load = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(ds_to_es_valid), 32'd0);
    chk({tag, "_allowin"}, 32'(ds_allowin), 32'd1);
    chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    chk({tag, "_inst"}, ds_inst, 32'd0);
    chk({tag, "_pc"}, ds_pc, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end

  initial begin : stim
    bit          acc;
    logic [31:0] add_r3_r1_r2;
    int          idx;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    add_r3_r1_r2 = {12'h001, 5'd0, 5'd2, 5'd1, 5'd3};

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_held");
    reset = 1'b0;
    #1;
    check_reset_state("rst_rel");
    tick(acc);

    // Plain add.w from the regfile.
    offer(add_r3_r1_r2);
    chk("d1_raddr1", 32'(raddr1), 32'd1);
    chk("d1_raddr2", 32'(raddr2), 32'd2);
    chk("d1_src1", src1_val, 32'd5);
    chk("d1_src2", src2_val, 32'd7);
    chk("d1_valid", 32'(ds_to_es_valid), 32'd1);
    tick(acc);

    // Forwarding priority: MEM beats WB on r1, EX supplies r2.
    ms_fwd_valid = 1'b1; ms_fwd_dest = 5'd1; ms_fwd_data = 32'h11;
    ws_fwd_valid = 1'b1; ws_fwd_dest = 5'd1; ws_fwd_data = 32'h22;
    es_fwd_valid = 1'b1; es_fwd_dest = 5'd2; es_fwd_data = 32'h33;
    offer(add_r3_r1_r2);
    chk("d2_src1", src1_val, 32'h11);
    chk("d2_src2", src2_val, 32'h33);
    tick(acc);
    clear_fwd();

    // Two-cycle load-use stall on r1.
    es_fwd_valid = 1'b1; es_fwd_dest = 5'd1; es_fwd_data = 32'hDEAD; es_is_load = 1'b1;
    offer(add_r3_r1_r2);
    chk("d3_valid_c1", 32'(ds_to_es_valid), 32'd0);
    chk("d3_allowin_c1", 32'(ds_allowin), 32'd0);
    tick(acc);
    chk("d3_valid_c2", 32'(ds_to_es_valid), 32'd0);
    chk("d3_allowin_c2", 32'(ds_allowin), 32'd0);
    tick(acc);
    clear_fwd();
    #1;
    chk("d3_stall_cnt", stall_cnt, 32'd2);
    chk("d3_issue", 32'(ds_to_es_valid), 32'd1);
    chk("d3_inst_held", ds_inst, add_r3_r1_r2);
    tick(acc);

    // st.w reads rd as its second source.
    offer(mk(K_STW, 5'd4, 5'd5, 5'd6));
    chk("d4_raddr2", 32'(raddr2), 32'd4);
    tick(acc);

    // lu12i.w does not read rj, so a pending load to r9 is harmless.
    es_fwd_valid = 1'b1; es_fwd_dest = 5'd9; es_is_load = 1'b1;
    offer(mk(K_LU12I, 5'd3, 5'd9, 5'd0));
    chk("d4_lu12i_nostall", 32'(ds_to_es_valid), 32'd1);
    tick(acc);
    clear_fwd();

    // Cancel while stalled: slot empties and no stall is counted.
    es_fwd_valid = 1'b1; es_fwd_dest = 5'd1; es_is_load = 1'b1;
    offer(add_r3_r1_r2);
    br_cancel = 1'b1;
    tick(acc);
    br_cancel = 1'b0;
    #1;
    chk("d5_valid", 32'(ds_to_es_valid), 32'd0);
    chk("d5_allowin", 32'(ds_allowin), 32'd1);
    chk("d5_stall_cnt", stall_cnt, 32'd2);
    clear_fwd();
    tick(acc);

    // r0 sources ignore forwards that target r0.
    es_fwd_valid = 1'b1; es_fwd_dest = 5'd0; es_fwd_data = 32'hFFFF;
    ms_fwd_valid = 1'b1; ms_fwd_dest = 5'd0; ms_fwd_data = 32'hFFFF;
    ws_fwd_valid = 1'b1; ws_fwd_dest = 5'd0; ws_fwd_data = 32'hFFFF;
    offer({12'h001, 5'd0, 5'd0, 5'd0, 5'd3});
    chk("d6_src1_r0", src1_val, 32'd0);
    chk("d6_src2_r0", src2_val, 32'd0);
    tick(acc);
    clear_fwd();

    // Reset while an instruction is held in a stall.
    es_fwd_valid = 1'b1; es_fwd_dest = 5'd2; es_is_load = 1'b1;
    offer(add_r3_r1_r2);
    reset = 1'b1;
    exp_q.delete();
    m_cnt = '0;
    #1;
    check_reset_state("rst_mid");
    tick(acc);
    reset = 1'b0;
    clear_fwd();
    tick(acc);

    // Random traffic.
    for (int c = 0; c < 500; c++) begin
      tick(acc);
      br_cancel    = ($urandom_range(0, 15) == 0);
      es_allowin   = ($urandom_range(0, 4) != 0);
      es_fwd_valid = 1'($urandom_range(0, 1));
      es_fwd_dest  = 5'($urandom_range(0, 7));
      es_fwd_data  = $urandom;
      es_is_load   = es_fwd_valid && ($urandom_range(0, 2) == 0);
      ms_fwd_valid = 1'($urandom_range(0, 1));
      ms_fwd_dest  = 5'($urandom_range(0, 7));
      ms_fwd_data  = $urandom;
      ws_fwd_valid = 1'($urandom_range(0, 1));
      ws_fwd_dest  = 5'($urandom_range(0, 7));
      ws_fwd_data  = $urandom;
      if (!fs_to_ds_valid || acc) begin
        fs_to_ds_valid = ($urandom_range(0, 3) != 0);
        fs_pc   = pc_ctr;
        pc_ctr  = pc_ctr + 32'd4;
        fs_inst = mk(kind_e'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      if (br_cancel) fs_to_ds_valid = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(1, 31);
        regs[idx] = $urandom;
      end
    end

    fs_to_ds_valid = 1'b0;
    br_cancel = 1'b0;
    es_allowin = 1'b1;
    clear_fwd();
    repeat (3) tick(acc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode-stage pipeline slot of the 5-stage LoongArch core. It sits directly upstream of the register file's read ports.
- Latches instruction and PC from IF and extracts source register numbers, which drive the regfile read addresses.
- Merges regfile read data with EX/MEM/WB forwarding and stalls on load-use hazards.
- Presents PC, instruction and resolved operands to EX under the allowin/valid pipeline handshake.

Parameters:
- PERF_W, 32, width of stall-cycle performance counter.

Ports:
- clk  in  1  core clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- fs_to_ds_valid  in  1  IF holds a valid instruction.
- fs_pc  in  32  PC of IF instruction.
- fs_inst  in  32  IF instruction word.
- ds_allowin  out  1  this stage can accept from IF this cycle.
- br_cancel  in  1  flush: discard the held instruction (taken branch resolved in EX).
- raddr1  out  5  regfile read address 1 (rj).
- raddr2  out  5  regfile read address 2 (rk or rd).
- rdata1  in  32  regfile read data 1; r0 reads as 0.
- rdata2  in  32  regfile read data 2; r0 reads as 0.
- es_fwd_valid / ms_fwd_valid / ws_fwd_valid  in  1 each  stage holds a valid register-writing instruction.
- es_fwd_dest / ms_fwd_dest / ws_fwd_dest  in  5 each  destination register.
- es_fwd_data / ms_fwd_data / ws_fwd_data  in  32 each  result value.
- es_is_load  in  1  EX instruction is a load; its data is not yet available.
- es_allowin  in  1  EX can accept.
- ds_to_es_valid  out  1  valid, hazard-free instruction offered to EX.
- ds_pc  out  32  held PC.
- ds_inst  out  32  held instruction.
- src1_val  out  32  resolved rj operand.
- src2_val  out  32  resolved second operand.
- stall_cnt  out  PERF_W  count of load-use stall cycles.

Behaviour:
- State: ds_valid, ds_pc, ds_inst, stall_cnt. Reset (async) clears all to 0, so ds_to_es_valid=0, ds_allowin=1, ds_pc=0, ds_inst=0, stall_cnt=0.
- Fields: rj=inst[9:5], rk=inst[14:10], rd=inst[4:0].
- src2_is_rd=1 for:
  - st.w: inst[31:22]=10'b0010100110
  - beq: inst[31:26]=6'b010110
  - bne: inst[31:26]=6'b010111
- raddr1=rj. raddr2 = src2_is_rd ? rd : rk.
- uses_rj=0 for:
  - lu12i.w: inst[31:25]=7'b0001010
  - b: inst[31:26]=6'b010100
  - bl: inst[31:26]=6'b010101
- uses_rj=1 for all other instructions.
- uses_src2=1 for:
  - 3R ops: inst[31:20]=12'h001
  - the src2_is_rd instructions.
- Forwarding per source, priority EX > MEM > WB > regfile.
  - A stage matches when its fwd_valid=1, its fwd_dest equals the source address, and the address is not 0.
  - Address 0 always yields 0.
- Load-use hazard: ds_valid, es_fwd_valid, es_is_load, es_fwd_dest!=0, and es_fwd_dest matching a used source.
- ds_ready_go = !hazard.
- ds_allowin = !ds_valid | (ds_ready_go & es_allowin).
- ds_to_es_valid = ds_valid & ds_ready_go & !br_cancel.
- Posedge update:
  - br_cancel=1: ds_valid<=0. IF is expected to gate its own valid the same cycle.
  - else if ds_allowin=1: ds_valid<=fs_to_ds_valid.
  - ds_pc/ds_inst load only when fs_to_ds_valid & ds_allowin & !br_cancel.
- Stall hold: ds_pc/ds_inst/ds_valid hold while stalled. Operands are re-resolved every cycle, so values must not be registered.
- stall_cnt increments by 1 each cycle with hazard=1 and br_cancel=0. It wraps at 2^PERF_W.
- Simultaneous events:
  - br_cancel during a stall: cancel wins and no count is taken.
  - EX and WB match the same register: EX data is used.
- Outputs other than ds_allowin/ds_to_es_valid are don't-care when ds_valid=0, but must be deterministic (no X) after reset.

Decomposition:
- Shared package: opcode constants OP_STW, OP_BEQ, OP_BNE, OP_LU12I, OP_B, OP_BL, OP_3R_PREFIX; field position constants.
- One natural sub-module: fwd_mux. It takes a 5-bit address, regfile data and three (valid, dest, data) triples, and outputs the 32-bit operand. It is instantiated twice.

Test Plan:
- Reset mid-stream: assert reset with ds_valid=1 -> next sample ds_to_es_valid=0, ds_allowin=1, stall_cnt=0, ds_inst=0.
- add.w r3,r1,r2 with rdata1=5, rdata2=7, no forwards -> raddr1=1, raddr2=2, src1_val=5, src2_val=7, ds_to_es_valid=1.
- Same add.w with ms fwd (r1, 0x11) and ws fwd (r1, 0x22) and es fwd (r2, 0x33) -> src1_val=0x11, src2_val=0x33.
- es_is_load=1, es_fwd_dest=1 for 2 cycles, es_allowin=1 -> ds_to_es_valid=0 and ds_allowin=0 for 2 cycles, stall_cnt=2, same inst then issues.
- st.w with rd=4 -> raddr2=4. lu12i.w with rj=9 and EX load to r9 -> no stall.
- br_cancel while stalled -> ds_valid=0 next cycle, stall_cnt unchanged. Source r0 with fwd dest=0 data 0xFFFF -> operand 0.
